// File: rtl/timer_pkg.sv
// Shared types and constants for the myTimer counting engine.
package timer_pkg;

  // Default datapath widths
  localparam int unsigned TMR_CNT_W   = 32;
  localparam int unsigned TMR_PRESC_W = 16;

  // Bit positions inside the sticky status vector
  localparam int unsigned FLG_W   = 3;
  localparam int unsigned FLG_EXP = 0;
  localparam int unsigned FLG_MAT = 1;
  localparam int unsigned FLG_CAP = 2;

  // Counting engine control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: down-counter that emits a one-cycle tick every prescale+1
// running cycles. A reload request restarts the period and suppresses any
// tick in the same cycle.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PRESC_W = TMR_PRESC_W
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               reload,
  input  logic               run,
  output logic               tick
);

  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] presc_cnt;

  assign tick = run && !reload && (presc_cnt == '0);

  // Reload has priority; while running count down and wrap back to prescale
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      presc_cnt <= '0;
    end else if (reload) begin
      presc_cnt <= prescale;
    end else if (run) begin
      if (presc_cnt == '0) begin
        presc_cnt <= prescale;
      end else begin
        presc_cnt <= presc_cnt - PRESC_ONE;
      end
    end
  end

endmodule

// File: rtl/timer_core.sv
// Counting engine of the myTimer AXI4-Lite peripheral: prescaled up-counter
// with one-shot / auto-reload modes, compare match, sticky flags and a level
// interrupt.
// Optional feature macro: TIMER_CAPTURE_EN (input-capture unit, status[2]).
module timer_core
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W   = TMR_CNT_W,
  parameter int unsigned PRESC_W = TMR_PRESC_W
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               ctrl_en,
  input  logic               ctrl_autoreload,
  input  logic               ctrl_irq_en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   compare,
  input  logic               cfg_load,
  input  logic [FLG_W-1:0]   flag_clr,
`ifdef TIMER_CAPTURE_EN
  input  logic               capture_in,
  output logic [CNT_W-1:0]   capture_val,
`endif
  output logic [CNT_W-1:0]   count,
  output logic [FLG_W-1:0]   status,
  output logic               busy,
  output logic               irq
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef TIMER_CAPTURE_EN
  localparam logic [FLG_W-1:0] FLG_MASK = 3'b111;
`else
  localparam logic [FLG_W-1:0] FLG_MASK = 3'b011;
`endif

  timer_state_e      state;
  timer_state_e      state_nxt;
  logic              tick;
  logic              presc_run;
  logic              presc_reload;
  logic              at_term;
  logic [CNT_W-1:0]  count_nxt;
  logic              set_exp;
  logic              set_mat;
  logic              cap_edge;
  logic [FLG_W-1:0]  flg_set;
  logic [FLG_W-1:0]  status_nxt;

  // Prescaler runs only while enabled in RUN; it restarts on cfg_load and
  // on the IDLE->RUN entry so the first tick lands prescale+1 cycles later
  assign presc_run    = (state == RUN) && ctrl_en;
  assign presc_reload = cfg_load || ((state == IDLE) && ctrl_en);

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .prescale (prescale),
    .reload   (presc_reload),
    .run      (presc_run),
    .tick     (tick)
  );

  // A count already past period (period lowered without a restart) is
  // treated as terminal rather than wrapping through 2^CNT_W
  assign at_term = (count >= period);

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: cfg_load overrides every other transition
  always_comb begin
    state_nxt = state;
    if (cfg_load) begin
      state_nxt = ctrl_en ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: if (ctrl_en) state_nxt = RUN;
        RUN: begin
          if (!ctrl_en) begin
            state_nxt = IDLE;
          end else if (tick && at_term && !ctrl_autoreload) begin
            state_nxt = DONE;
          end
        end
        DONE:    if (!ctrl_en) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Count update and match/expiry detection on each tick
  always_comb begin
    count_nxt = count;
    set_exp   = 1'b0;
    set_mat   = 1'b0;
    if (cfg_load) begin
      count_nxt = '0;
    end else if (tick) begin
      if (at_term) begin
        set_exp = 1'b1;
        if (ctrl_autoreload) begin
          count_nxt = '0;
        end
      end else begin
        count_nxt = count + CNT_ONE;
      end
      set_mat = (count_nxt == compare);
    end
  end

  // Count register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic cap_s1;
  logic cap_s2;
  logic cap_s3;

  // Two-flop synchronizer plus one delay stage for rising-edge detection
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cap_s1 <= 1'b0;
      cap_s2 <= 1'b0;
      cap_s3 <= 1'b0;
    end else begin
      cap_s1 <= capture_in;
      cap_s2 <= cap_s1;
      cap_s3 <= cap_s2;
    end
  end

  assign cap_edge = cap_s2 && !cap_s3;

  // Latch the live count on every detected edge, in any state
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      capture_val <= '0;
    end else if (cap_edge) begin
      capture_val <= count;
    end
  end
`else
  assign cap_edge = 1'b0;
`endif

  // Sticky flags: clear first, then set, so a simultaneous set wins
  always_comb begin
    flg_set          = '0;
    flg_set[FLG_EXP] = set_exp;
    flg_set[FLG_MAT] = set_mat;
    flg_set[FLG_CAP] = cap_edge;
    status_nxt       = ((status & ~flag_clr) | flg_set) & FLG_MASK;
  end

  // Status register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      status <= '0;
    end else begin
      status <= status_nxt;
    end
  end

  assign busy = (state == RUN);
  assign irq  = ctrl_irq_en && (|status);

endmodule
